riscvsys_memarb: RTL

Two-master arbiter that shares the single testbench memory port (picorv32 native valid/ready bus) between the CPU and a second bus master (DMA or debug loader). It grants one requester per transaction with round-robin fairness. It forwards the granted request to the memory port and routes the response back. A watchdog terminates any transaction the target leaves unanswered, returning an error word instead of hanging the CPU.

---
 rtl/riscvsys_memarb_pkg.sv | 25 ++
 rtl/riscvsys_memarb_rr.sv | 30 +++
 rtl/riscvsys_memarb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/riscvsys_memarb_pkg.sv
// ---------------------------------------------------------------------------
// riscvsys_memarb_pkg
// Shared types for the two-master memory arbiter:
//   state_e    - arbiter FSM states (idle / transaction granted)
//   req_idx_t  - requester index (0 = CPU, 1 = second bus master)
//   bus_req_t  - one requester's native-bus request fields
// ---------------------------------------------------------------------------
package riscvsys_memarb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef logic req_idx_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

endpackage

// File: rtl/riscvsys_memarb_rr.sv
// ---------------------------------------------------------------------------
// riscvsys_memarb_rr
// Purely combinational 2-way round-robin picker.
// Ports:
//   valid      in  2  request valids, bit N = requester N
//   last       in  1  requester that completed the previous transaction
//   winner     out 1  chosen requester (0 when nothing is valid)
//   any_valid  out 1  at least one requester is valid
// ---------------------------------------------------------------------------
module riscvsys_memarb_rr
  import riscvsys_memarb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_idx_t   last,
  output req_idx_t   winner,
  output logic       any_valid
);

  always_comb begin
    any_valid = |valid;
    // On a tie the requester that did not go last wins; otherwise the single
    // valid requester wins (bit 1 alone selects index 1, anything else 0).
    if (valid == 2'b11) begin
      winner = ~last;
    end else begin
      winner = valid[1];
    end
  end

endmodule

// File: rtl/riscvsys_memarb.sv
// ---------------------------------------------------------------------------
// riscvsys_memarb
// Shares one picorv32-style valid/ready memory port between the CPU (r0) and a
// second bus master (r1). One transaction is granted at a time with
// round-robin fairness; a watchdog ends any transaction the target never
// answers, returning ERR_RDATA and pulsing o_err.
// Ports:
//   i_clk, i_rstn             clock, async active-low reset
//   i_rN_valid/addr/wdata/wstrb  requester N request (wstrb 0 = read)
//   o_rN_ready/rdata          requester N one-cycle completion and read data
//   o_t_valid/addr/wdata/wstrb   request forwarded to the memory target
//   i_t_ready/rdata           target completion and read data
//   o_err                     one-cycle pulse on watchdog termination
//   o_err_addr                address of the last terminated transaction
// Parameters:
//   TIMEOUT    GRANT cycles allowed before termination, 0 disables
//   ERR_RDATA  read data returned on a terminated transaction
// ---------------------------------------------------------------------------
module riscvsys_memarb
  import riscvsys_memarb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'hdead_beef
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_r0_valid,
  input  logic [31:0] i_r0_addr,
  input  logic [31:0] i_r0_wdata,
  input  logic [3:0]  i_r0_wstrb,
  output logic        o_r0_ready,
  output logic [31:0] o_r0_rdata,
  input  logic        i_r1_valid,
  input  logic [31:0] i_r1_addr,
  input  logic [31:0] i_r1_wdata,
  input  logic [3:0]  i_r1_wstrb,
  output logic        o_r1_ready,
  output logic [31:0] o_r1_rdata,
  output logic        o_t_valid,
  output logic [31:0] o_t_addr,
  output logic [31:0] o_t_wdata,
  output logic [3:0]  o_t_wstrb,
  input  logic        i_t_ready,
  input  logic [31:0] i_t_rdata,
  output logic        o_err,
  output logic [31:0] o_err_addr
);

  // Watchdog counter wide enough to hold TIMEOUT; kept at 1 bit when disabled.
  localparam int unsigned     WDW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              WDOG_EN   = (TIMEOUT > 0);
  localparam logic [WDW-1:0]  WDOG_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [WDW-1:0]  WDOG_MAX  = {WDW{1'b1}};

  state_e         state_q;
  req_idx_t       gnt_q;
  req_idx_t       last_q;
  logic [WDW-1:0] wdog_q;
  logic [31:0]    err_addr_q;

  bus_req_t           req [NUM_REQ];
  logic [NUM_REQ-1:0] valid_vec;
  bus_req_t           gnt_req;
  logic               gnt_valid;
  logic               in_grant;
  logic               done;
  logic               tmo;
  logic [31:0]        rsp_word;
  req_idx_t           pick;
  logic               any_valid;
  logic [NUM_REQ-1:0] rsp_ready;
  logic [31:0]        rsp_rdata [NUM_REQ];

  assign req[0] = '{addr: i_r0_addr, wdata: i_r0_wdata, wstrb: i_r0_wstrb};
  assign req[1] = '{addr: i_r1_addr, wdata: i_r1_wdata, wstrb: i_r1_wstrb};
  assign valid_vec = {i_r1_valid, i_r0_valid};

  riscvsys_memarb_rr u_rr (
    .valid     (valid_vec),
    .last      (last_q),
    .winner    (pick),
    .any_valid (any_valid)
  );

  assign in_grant  = (state_q == ST_GRANT);
  assign gnt_req   = req[gnt_q];
  assign gnt_valid = valid_vec[gnt_q];

  // A target ready in the same cycle as the timeout wins: tmo requires !i_t_ready.
  assign done = in_grant && gnt_valid && i_t_ready;
  assign tmo  = WDOG_EN && in_grant && gnt_valid && !i_t_ready && (wdog_q == WDOG_LAST);

  // The terminating cycle withdraws the request so the target never sees a
  // completion it could mistake for its own.
  assign o_t_valid = in_grant && gnt_valid && !tmo;
  assign o_t_addr  = in_grant ? gnt_req.addr  : 32'h0;
  assign o_t_wdata = in_grant ? gnt_req.wdata : 32'h0;
  assign o_t_wstrb = in_grant ? gnt_req.wstrb : 4'h0;

  assign rsp_word = tmo ? ERR_RDATA : i_t_rdata;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_ready[gi] = (done || tmo) && (gnt_q == req_idx_t'(gi));
    assign rsp_rdata[gi] = rsp_ready[gi] ? rsp_word : 32'h0;
  end

  assign o_r0_ready = rsp_ready[0];
  assign o_r0_rdata = rsp_rdata[0];
  assign o_r1_ready = rsp_ready[1];
  assign o_r1_rdata = rsp_rdata[1];

  assign o_err      = tmo;
  assign o_err_addr = err_addr_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;   // requester 0 wins the first tie
      wdog_q     <= '0;
      err_addr_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            gnt_q   <= pick;
            wdog_q  <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Completion, termination, or a requester abandoning its request
          // all end the transaction and count as that requester's turn.
          if (!gnt_valid || done || tmo) begin
            last_q  <= gnt_q;
            state_q <= ST_IDLE;
          end else if (wdog_q != WDOG_MAX) begin
            wdog_q <= wdog_q + 1'b1;
          end
          if (tmo) begin
            err_addr_q <= gnt_req.addr;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
